pwm_capture: RTL

//  Receive side of the PWM link. Measures an incoming PWM waveform and reports
//  its high width, its period and the quantized duty code the transmitter encoded.
//  The transmitter encodes high width as {0, code[2:0], 1, 9'd0} over a 2^14-cycle

---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_in_sync.sv | 23 ++
 rtl/pwm_capture.sv | 96 +++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and state type for the PWM receive path.
// The transmitter encodes high width as {0, code, 1, zeros} over a 2^CBITS period.
package pwm_pkg;

   localparam int CBITS        = 14;
   localparam int CNT_W_DEF    = CBITS + 1;
   localparam int CODE_W_DEF   = 3;
   localparam int CODE_LSB_DEF = CBITS - 4;
   localparam int TIMEOUT_DEF  = 20000;

   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      LOW
   } pwm_cap_state_t;

endpackage

// File: rtl/pwm_in_sync.sv
// Two-flop synchronizer for the raw PWM pad plus a third flop for edge detection.
// level/rise/fall are all derived from the second (metastability-safe) stage.
module pwm_in_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic pwm_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [2:0] sh;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sh <= '0;
      else        sh <= {sh[1:0], pwm_in};
   end

   assign level = sh[1];
   assign rise  = sh[1] & ~sh[2];
   assign fall  = ~sh[1] & sh[2];

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: measures high width and period between rising edges, recovers the
// duty code, and flags a line that has stopped toggling.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int CNT_W    = CNT_W_DEF,
   parameter int CODE_W   = CODE_W_DEF,
   parameter int CODE_LSB = CODE_LSB_DEF,
   parameter int TIMEOUT  = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pwm_in,
   output logic [CNT_W-1:0]  high_width,
   output logic [CNT_W-1:0]  period,
   output logic [CODE_W-1:0] duty_code,
   output logic              meas_valid,
   output logic              stuck,
   output logic              stuck_level
);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam int               IDLE_W   = $clog2(TIMEOUT + 1);
   localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(TIMEOUT);

   logic              level, rise, fall, edge_any, timeout;
   logic [CNT_W-1:0]  run_cnt, hw_lat;
   logic [IDLE_W-1:0] idle_cnt;
   pwm_cap_state_t    state;

   pwm_in_sync u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .pwm_in (pwm_in),
      .level  (level),
      .rise   (rise),
      .fall   (fall)
   );

   assign edge_any = rise | fall;
   // An edge in the same cycle as the limit wins over the timeout.
   assign timeout  = (idle_cnt == IDLE_LIM) && !edge_any && !stuck;

   // Saturating so an overlong period clamps to CNT_MAX instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  run_cnt <= '0;
      else if (rise)               run_cnt <= CNT_W'(1);
      else if (run_cnt != CNT_MAX) run_cnt <= run_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    idle_cnt <= '0;
      else if (edge_any)             idle_cnt <= '0;
      else if (idle_cnt != IDLE_LIM) idle_cnt <= idle_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         hw_lat      <= '0;
         high_width  <= '0;
         period      <= '0;
         duty_code   <= '0;
         meas_valid  <= 1'b0;
         stuck       <= 1'b0;
         stuck_level <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         if (edge_any) stuck <= 1'b0;
         if (timeout) begin
            stuck       <= 1'b1;
            stuck_level <= level;
            state       <= IDLE;
         end else begin
            case (state)
               IDLE: if (rise) state <= HIGH;
               // A rise while HIGH means the fall was lost; run_cnt restarts
               // on that rise, so staying HIGH restarts the measurement.
               HIGH: if (fall) begin
                  hw_lat <= run_cnt;
                  state  <= LOW;
               end
               LOW: if (rise) begin
                  period     <= run_cnt;
                  high_width <= hw_lat;
                  duty_code  <= hw_lat[CODE_LSB +: CODE_W];
                  meas_valid <= 1'b1;
                  state      <= HIGH;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
